mu0_memory: RTL and testbench
=============================

MU0_MEMORY -- requirements
Module: mu0_memory

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset; sampled on rising Clk.
REQ-003 Rd  input  1  CPU read strobe.
REQ-004 Wr  input  1  CPU write strobe.
REQ-005 Addr  input  12  CPU word address.
REQ-006 Data_in  input  16  write data from CPU (CPU Data_out).
REQ-007 Data_out  output  16  read data to CPU (CPU Data_in).
REQ-008 Halted  input  1  CPU halted flag; freezes cycle counter.
REQ-009 Leds  output  16  LED register contents.
REQ-010 Tx_data  output  16  head word of transmit FIFO.
REQ-011 Tx_valid  output  1  FIFO non-empty.
REQ-012 Tx_ready  input  1  host accepts head word this cycle.
REQ-013 Bus_err  output  1  sticky flag: Rd and Wr asserted together.

Function
REQ-014 Address map SHALL be: 0x000-0xFEF RAM; 0xFF0 LED reg (R/W); 0xFF1 TX data (W push, reads 0x0000); 0xFF2 TX status (R; W clears overflow); 0xFF3 cycle counter (R; W clears); 0xFF4-0xFFF reserved (read 0x0000, writes ignored).
REQ-015 Reads SHALL be combinational, zero wait states: Data_out valid in the same cycle Rd and Addr are presented.
REQ-016 Data_out SHALL be 0x0000 whenever Rd is low.
REQ-017 Writes SHALL take effect at the rising Clk edge where Wr is high; read in the following cycle returns the new value.
REQ-018 RAM SHALL be 4080 x 16 words, addressed by Addr directly.
REQ-019 TX status word SHALL be: bit0 full, bit1 empty, bits4:2 count (0-4), bit5 sticky overflow, bits15:6 zero.
REQ-020 TX FIFO SHALL be 4 entries deep, first-in first-out; Tx_data = head entry, Tx_valid = not empty.
REQ-021 A pop SHALL occur on each rising edge where Tx_valid and Tx_ready are both high.
REQ-022 Write to 0xFF1 while not full SHALL push Data_in.
REQ-023 Write to 0xFF1 while full without same-cycle pop SHALL drop the word and set overflow.
REQ-024 Write to 0xFF1 while full with same-cycle pop SHALL push and pop; count stays 4, no overflow.
REQ-025 Write to 0xFF1 while empty with Tx_ready high SHALL push only (no pop since Tx_valid low); count becomes 1.
REQ-026 FIFO pointers SHALL wrap modulo 4.
REQ-027 Tx_data SHALL be held stable while Tx_valid is high and Tx_ready is low.
REQ-028 Cycle counter SHALL be 16 bits, increment every cycle Halted is low, hold while Halted is high, wrap 0xFFFF to 0x0000.
REQ-029 Write to 0xFF3 SHALL load 0x0000 (clear overrides increment that cycle).
REQ-030 When Rd and Wr are both high, the write SHALL be performed, Data_out SHALL be 0x0000, and Bus_err SHALL set from the next cycle.

Reset
REQ-031 Reset SHALL clear Leds, cycle counter, FIFO pointers/count (Tx_valid 0), overflow, and Bus_err to 0 on the next rising edge.
REQ-032 Reset SHALL NOT alter RAM contents or FIFO storage; Tx_data is don't-care while empty.
REQ-033 Reset SHALL take priority over any simultaneous write, push, pop or increment; an entry mid-transfer is discarded.

Structure
REQ-034 Address map constants, FIFO depth, and status bit positions SHALL reside in shared package mu0_pkg.
REQ-035 The transmit FIFO SHALL be a separate sub-module mu0_tx_fifo (push, pop, full, empty, count, overflow).
REQ-036 Address decode and read mux SHALL be combinational in mu0_memory.

Verification
REQ-037 Write 0x1234 to 0x005, read 0x005 next cycle -> Data_out 0x1234; Rd low -> Data_out 0x0000.
REQ-038 Push 0xA001-0xA005 with Tx_ready low -> status 0x0011 then 0x0031 after fifth push; Tx_data 0xA001.
REQ-039 Full FIFO, write 0xB000 with Tx_ready high -> Tx_data becomes 0xA002, count 4, overflow unchanged; drain yields A002,A003,A004,B000 then Tx_valid 0.
REQ-040 Reset, Halted low 10 cycles, then Halted high 5 cycles -> 0xFF3 reads 0x000A; write 0xFF3 -> next read 0x0001 when Halted low.
REQ-041 Rd=Wr=1 at 0x010 with Data_in 0x5555 -> Data_out 0x0000, RAM[0x010]=0x5555, Bus_err 1 until Reset.
REQ-042 Reset asserted with FIFO count 3 and Leds 0x00FF -> next cycle Tx_valid 0, Leds 0x0000, RAM unchanged.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared constants for the MU0 memory subsystem: address map, TX FIFO geometry,
// status word layout and the address decoder.
package mu0_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 12;
  localparam int RAM_WORDS  = 4080;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  localparam logic [ADDR_W-1:0] ADDR_RAM_END = 12'hFF0;
  localparam logic [ADDR_W-1:0] ADDR_LED     = 12'hFF0;
  localparam logic [ADDR_W-1:0] ADDR_TX_DATA = 12'hFF1;
  localparam logic [ADDR_W-1:0] ADDR_TX_STAT = 12'hFF2;
  localparam logic [ADDR_W-1:0] ADDR_CYCLES  = 12'hFF3;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_CNT_LO = 2;
  localparam int ST_OVF    = 5;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LED,
    REG_TX_DATA,
    REG_TX_STAT,
    REG_CYCLES,
    REG_RSVD
  } region_e;

  function automatic region_e decode(input logic [ADDR_W-1:0] addr);
    region_e r;
    if (addr < ADDR_RAM_END) begin
      r = REG_RAM;
    end else begin
      case (addr)
        ADDR_LED:     r = REG_LED;
        ADDR_TX_DATA: r = REG_TX_DATA;
        ADDR_TX_STAT: r = REG_TX_STAT;
        ADDR_CYCLES:  r = REG_CYCLES;
        default:      r = REG_RSVD;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] tx_status(input logic full, input logic empty,
                                                  input logic [CNT_W-1:0] count,
                                                  input logic ovf);
    logic [DATA_W-1:0] s;
    s                            = '0;
    s[ST_FULL]                   = full;
    s[ST_EMPTY]                  = empty;
    s[ST_CNT_LO +: CNT_W]        = count;
    s[ST_OVF]                    = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mu0_memory_if.sv
// CPU/host-facing bus of the MU0 memory: CPU read/write port, LEDs and TX stream.
interface mu0_memory_if;
    import mu0_pkg::*;

    logic              Rd;
    logic              Wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;
    logic              Halted;
    logic [DATA_W-1:0] Leds;
    logic [DATA_W-1:0] Tx_data;
    logic              Tx_valid;
    logic              Tx_ready;
    logic              Bus_err;

    modport master (
        output Rd, Wr, Addr, Data_in, Halted, Tx_ready,
        input  Data_out, Leds, Tx_data, Tx_valid, Bus_err
    );

    modport slave (
        input  Rd, Wr, Addr, Data_in, Halted, Tx_ready,
        output Data_out, Leds, Tx_data, Tx_valid, Bus_err
    );
endinterface

// File: rtl/mu0_tx_fifo.sv
// Four-entry transmit FIFO with sticky overflow; a push into a full FIFO is
// accepted only when the head is popped in the same cycle.
module mu0_tx_fifo
    import mu0_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop;
    logic              push_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign pop     = !empty && pop_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end

    // Storage is never cleared; a write during reset is blocked so contents survive.
    always_ff @(posedge Clk) begin
        if (push_ok && !Reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mu0_memory.sv
// MU0 memory subsystem: 4080-word RAM plus LED, TX FIFO and cycle-counter
// registers, with zero-wait-state combinational reads.
module mu0_memory
    import mu0_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    mu0_memory_if.slave  bus
);

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [DATA_W-1:0] leds;
    logic [DATA_W-1:0] cycles;
    logic              bus_err;
    region_e           region;
    logic [DATA_W-1:0] rd_mux;

    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_ovf;
    logic [DATA_W-1:0] tx_head;

    assign region = decode(bus.Addr);

    mu0_tx_fifo u_tx_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (bus.Wr && region == REG_TX_DATA),
        .push_data (bus.Data_in),
        .pop_ready (bus.Tx_ready),
        .clr_ovf   (bus.Wr && region == REG_TX_STAT),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .overflow  (tx_ovf)
    );

    always_comb begin
        rd_mux = '0;
        case (region)
            REG_RAM:     rd_mux = ram[bus.Addr];
            REG_LED:     rd_mux = leds;
            REG_TX_STAT: rd_mux = tx_status(tx_full, tx_empty, tx_count, tx_ovf);
            REG_CYCLES:  rd_mux = cycles;
            default:     rd_mux = '0;
        endcase
    end

    // A simultaneous read and write is a bus error: the read returns zero.
    assign bus.Data_out = (bus.Rd && !bus.Wr) ? rd_mux : '0;
    assign bus.Leds     = leds;
    assign bus.Tx_data  = tx_head;
    assign bus.Tx_valid = !tx_empty;
    assign bus.Bus_err  = bus_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            leds    <= '0;
            cycles  <= '0;
            bus_err <= 1'b0;
        end else begin
            if (bus.Wr && region == REG_LED) leds <= bus.Data_in;
            if (bus.Wr && region == REG_CYCLES) cycles <= '0;
            else if (!bus.Halted)               cycles <= cycles + 1'b1;
            if (bus.Rd && bus.Wr) bus_err <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (bus.Wr && region == REG_RAM && !Reset) ram[bus.Addr] <= bus.Data_in;
    end

endmodule

// File: tb/tb_mu0_memory.sv
// Directed bench for mu0_memory: RAM, registers, TX FIFO, cycle counter, bus error, reset.
module tb_mu0_memory;
    import mu0_pkg::*;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    mu0_memory_if bus ();

    mu0_memory dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        bus.Rd = 1'b0; bus.Wr = 1'b1; bus.Addr = a; bus.Data_in = d;
        tick();
        bus.Wr = 1'b0;
    endtask

    task automatic set_read(input logic [11:0] a);
        bus.Wr = 1'b0; bus.Rd = 1'b1; bus.Addr = a;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (bus.Leds !== 16'h0000) begin errors++; $display("FAIL reset_leds got %h want 0000", bus.Leds); end
        checks++;
        if (bus.Tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got %b want 0", bus.Tx_valid); end
        checks++;
        if (bus.Bus_err !== 1'b0) begin errors++; $display("FAIL reset_buserr got %b want 0", bus.Bus_err); end
        set_read(ADDR_CYCLES);
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL reset_cycles got %h want 0000", bus.Data_out); end
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0002) begin errors++; $display("FAIL reset_status got %h want 0002", bus.Data_out); end
        bus.Rd = 1'b0;
    endtask

    task automatic test_ram_regs();
        do_write(12'h005, 16'h1234);
        set_read(12'h005);
        checks++;
        if (bus.Data_out !== 16'h1234) begin errors++; $display("FAIL ram_read got %h want 1234", bus.Data_out); end
        bus.Rd = 1'b0; #1;
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL rd_low got %h want 0000", bus.Data_out); end
        do_write(12'hFEF, 16'hBEEF);
        set_read(12'hFEF);
        checks++;
        if (bus.Data_out !== 16'hBEEF) begin errors++; $display("FAIL ram_top got %h want beef", bus.Data_out); end
        do_write(ADDR_LED, 16'h0F0F);
        checks++;
        if (bus.Leds !== 16'h0F0F) begin errors++; $display("FAIL leds got %h want 0f0f", bus.Leds); end
        set_read(ADDR_LED);
        checks++;
        if (bus.Data_out !== 16'h0F0F) begin errors++; $display("FAIL led_read got %h want 0f0f", bus.Data_out); end
        do_write(12'hFF8, 16'h7777);
        set_read(12'hFF8);
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL rsvd_read got %h want 0000", bus.Data_out); end
        bus.Rd = 1'b0;
    endtask

    task automatic test_fifo_fill();
        logic [15:0] w;
        bus.Tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w = 16'hA000 + 16'(i);
            do_write(ADDR_TX_DATA, w);
        end
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0011) begin errors++; $display("FAIL status_full got %h want 0011", bus.Data_out); end
        do_write(ADDR_TX_DATA, 16'hA005);
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0031) begin errors++; $display("FAIL status_ovf got %h want 0031", bus.Data_out); end
        checks++;
        if (bus.Tx_data !== 16'hA001) begin errors++; $display("FAIL head_a001 got %h want a001", bus.Tx_data); end
        set_read(ADDR_TX_DATA);
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL txdata_read got %h want 0000", bus.Data_out); end
        bus.Rd = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'hA002; exp_q[1] = 16'hA003; exp_q[2] = 16'hA004; exp_q[3] = 16'hB000;
        bus.Tx_ready = 1'b1;
        do_write(ADDR_TX_DATA, 16'hB000);
        bus.Tx_ready = 1'b0;
        checks++;
        if (bus.Tx_data !== 16'hA002) begin errors++; $display("FAIL pp_head got %h want a002", bus.Tx_data); end
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0031) begin errors++; $display("FAIL pp_status got %h want 0031", bus.Data_out); end
        bus.Rd = 1'b0;
        tick();
        checks++;
        if (bus.Tx_data !== 16'hA002) begin errors++; $display("FAIL hold_head got %h want a002", bus.Tx_data); end
        bus.Tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.Tx_valid !== 1'b1 || bus.Tx_data !== exp_q[i]) begin
                errors++; $display("FAIL drain_%0d got %h/%b want %h/1", i, bus.Tx_data, bus.Tx_valid, exp_q[i]);
            end
            tick();
        end
        bus.Tx_ready = 1'b0;
        checks++;
        if (bus.Tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", bus.Tx_valid); end
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0022) begin errors++; $display("FAIL empty_ovf got %h want 0022", bus.Data_out); end
        do_write(ADDR_TX_STAT, 16'hFFFF);
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0002) begin errors++; $display("FAIL ovf_clear got %h want 0002", bus.Data_out); end
        bus.Rd = 1'b0;
        bus.Tx_ready = 1'b1;
        do_write(ADDR_TX_DATA, 16'hC001);
        bus.Tx_ready = 1'b0;
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h0004 || bus.Tx_data !== 16'hC001) begin
            errors++; $display("FAIL push_empty_ready got %h/%h want 0004/c001", bus.Data_out, bus.Tx_data);
        end
        bus.Rd = 1'b0;
        bus.Tx_ready = 1'b1;
        tick();
        bus.Tx_ready = 1'b0;
        checks++;
        if (bus.Tx_valid !== 1'b0) begin errors++; $display("FAIL pop_single got %b want 0", bus.Tx_valid); end
    endtask

    task automatic test_counter();
        bus.Halted = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Halted = 1'b0;
        repeat (10) tick();
        bus.Halted = 1'b1;
        repeat (5) tick();
        set_read(ADDR_CYCLES);
        checks++;
        if (bus.Data_out !== 16'h000A) begin errors++; $display("FAIL cycles_10 got %h want 000a", bus.Data_out); end
        bus.Halted = 1'b0;
        do_write(ADDR_CYCLES, 16'h1234);
        set_read(ADDR_CYCLES);
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL cycles_clr got %h want 0000", bus.Data_out); end
        tick();
        checks++;
        if (bus.Data_out !== 16'h0001) begin errors++; $display("FAIL cycles_1 got %h want 0001", bus.Data_out); end
        bus.Halted = 1'b1;
        bus.Rd = 1'b0;
    endtask

    task automatic test_bus_err();
        bus.Rd = 1'b1; bus.Wr = 1'b1; bus.Addr = 12'h010; bus.Data_in = 16'h5555;
        #1;
        checks++;
        if (bus.Data_out !== 16'h0000) begin errors++; $display("FAIL rdwr_data got %h want 0000", bus.Data_out); end
        tick();
        bus.Wr = 1'b0; bus.Rd = 1'b0;
        checks++;
        if (bus.Bus_err !== 1'b1) begin errors++; $display("FAIL buserr_set got %b want 1", bus.Bus_err); end
        set_read(12'h010);
        checks++;
        if (bus.Data_out !== 16'h5555) begin errors++; $display("FAIL rdwr_ram got %h want 5555", bus.Data_out); end
        bus.Rd = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.Bus_err !== 1'b1) begin errors++; $display("FAIL buserr_sticky got %b want 1", bus.Bus_err); end
    endtask

    task automatic test_reset_mid();
        bus.Tx_ready = 1'b0;
        do_write(ADDR_TX_DATA, 16'hD001);
        do_write(ADDR_TX_DATA, 16'hD002);
        do_write(ADDR_TX_DATA, 16'hD003);
        do_write(ADDR_LED, 16'h00FF);
        set_read(ADDR_TX_STAT);
        checks++;
        if (bus.Data_out !== 16'h000C || bus.Leds !== 16'h00FF) begin
            errors++; $display("FAIL pre_reset got %h/%h want 000c/00ff", bus.Data_out, bus.Leds);
        end
        bus.Rd = 1'b0;
        Reset = 1'b1;
        bus.Wr = 1'b1; bus.Addr = 12'h005; bus.Data_in = 16'hDEAD;
        tick();
        Reset = 1'b0;
        bus.Wr = 1'b0;
        checks++;
        if (bus.Tx_valid !== 1'b0 || bus.Leds !== 16'h0000 || bus.Bus_err !== 1'b0) begin
            errors++; $display("FAIL post_reset got v=%b leds=%h err=%b want 0/0000/0", bus.Tx_valid, bus.Leds, bus.Bus_err);
        end
        set_read(12'h005);
        checks++;
        if (bus.Data_out !== 16'h1234) begin errors++; $display("FAIL ram_kept got %h want 1234", bus.Data_out); end
        set_read(12'h010);
        checks++;
        if (bus.Data_out !== 16'h5555) begin errors++; $display("FAIL ram_kept2 got %h want 5555", bus.Data_out); end
        bus.Rd = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b0;
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.Data_in = '0;
        bus.Halted = 1'b1; bus.Tx_ready = 1'b0;
        #2;
        test_reset();
        test_ram_regs();
        test_fifo_fill();
        test_push_pop_full();
        test_counter();
        test_bus_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
